// File: rtl/lsu_mem_master_if.sv
// lsu_mem_master_if: request/response/memory bundle; master = load/store unit side, slave = core+memory side
interface lsu_mem_master_if #(parameter int ADDR_W = 32);
  logic req_valid;
  logic req_ready;
  logic req_write;
  logic [1:0] req_size;
  logic req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0] req_wdata;
  logic rsp_valid;
  logic [31:0] rsp_rdata;
  logic rsp_error;
  logic [ADDR_W-1:0] mem_address;
  logic [31:0] mem_write_data;
  logic mem_write_enable;
  logic [31:0] mem_read_data;
  modport master (
    input req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_read_data,
    output req_ready, rsp_valid, rsp_rdata, rsp_error, mem_address, mem_write_data, mem_write_enable
  );
  modport slave (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_read_data,
    input req_ready, rsp_valid, rsp_rdata, rsp_error, mem_address, mem_write_data, mem_write_enable
  );
endinterface

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: load/store initiator with read-merge-write sub-word stores; ports clk, reset, bus (lsu_mem_master_if.master)
module lsu_mem_master #(
  parameter int ADDR_W = 32
) (
  input logic clk,
  input logic reset,
  lsu_mem_master_if.master bus
);
  typedef enum logic [2:0] {IDLE, LOAD, MERGE, STORE, RESP} state_t;
  state_t state, state_n;
  logic [1:0] r_size;
  logic r_uns;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0] r_word;
  logic [31:0] rdata_q;
  logic err_q;
  logic acc, req_err;
  logic [4:0] sh;
  logic [31:0] lane, ext, keep, merged;
  always_comb begin
    req_err = bus.req_size == 2'b11 || (bus.req_size == 2'b01 && bus.req_addr[0]) ||
              (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00);
    acc = state == IDLE && !reset && bus.req_valid;
    sh = {r_addr[1:0], 3'b000};
    lane = bus.mem_read_data >> sh;
    ext = r_size == 2'b00 ? {{24{!r_uns && lane[7]}}, lane[7:0]} :
          r_size == 2'b01 ? {{16{!r_uns && lane[15]}}, lane[15:0]} : lane;
    keep = r_size == 2'b00 ? 32'h0000_00ff : 32'h0000_ffff;
    merged = (bus.mem_read_data & ~(keep << sh)) | ((r_word & keep) << sh);
    state_n = state == IDLE ? (!acc ? IDLE : req_err ? RESP : !bus.req_write ? LOAD :
                               bus.req_size == 2'b10 ? STORE : MERGE) :
              state == LOAD ? RESP :
              state == MERGE ? STORE :
              state == STORE ? RESP : IDLE;
  end
  always_comb begin
    bus.req_ready = state == IDLE && !reset;
    bus.mem_address = (state == LOAD || state == MERGE || state == STORE) ? {r_addr[ADDR_W-1:2], 2'b00} : '0;
    bus.mem_write_data = state == STORE ? r_word : '0;
    bus.mem_write_enable = state == STORE && !reset;
    bus.rsp_valid = state == RESP && !reset;
    bus.rsp_rdata = rdata_q;
    bus.rsp_error = err_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      r_size <= '0;
      r_uns <= 1'b0;
      r_addr <= '0;
      r_word <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      if (acc) begin
        r_size <= bus.req_size;
        r_uns <= bus.req_unsigned;
        r_addr <= bus.req_addr;
        r_word <= bus.req_wdata;
      end
      if (acc && req_err) begin
        rdata_q <= '0;
        err_q <= 1'b1;
      end
      if (state == LOAD) begin
        rdata_q <= ext;
        err_q <= 1'b0;
      end
      if (state == MERGE) r_word <= merged;
      if (state == STORE) begin
        rdata_q <= '0;
        err_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_lsu_mem_master.sv
// tb_lsu_mem_master: directed scoreboard bench for lsu_mem_master against a word memory model
module tb_lsu_mem_master;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int last_acc = 0;
  int waited = 0;
  int prev = 0;
  typedef struct {logic [31:0] rd; logic err; int due;} rsp_t;
  typedef struct {logic [31:0] addr; logic [31:0] data; int due;} wr_t;
  rsp_t rq[$];
  wr_t wq[$];
  rsp_t er;
  wr_t ew;
  logic [31:0] mem [64];
  lsu_mem_master_if #(.ADDR_W(32)) bus();
  lsu_mem_master #(.ADDR_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  assign bus.mem_read_data = mem[bus.mem_address[7:2]];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    if (bus.rsp_valid === 1'b1) begin
      chk("rsp_expected", 32'(rq.size() != 0), 32'd1);
      if (rq.size() != 0) begin
        er = rq.pop_front();
        chk("rsp_rdata", bus.rsp_rdata, er.rd);
        chk("rsp_error", 32'(bus.rsp_error), 32'(er.err));
        chk("rsp_cycle", cyc, er.due);
      end
    end
    if (bus.mem_write_enable === 1'b1) begin
      chk("write_expected", 32'(wq.size() != 0), 32'd1);
      if (wq.size() != 0) begin
        ew = wq.pop_front();
        chk("write_addr", bus.mem_address, ew.addr);
        chk("write_data", bus.mem_write_data, ew.data);
        chk("write_cycle", cyc, ew.due);
      end
      mem[bus.mem_address[7:2]] = bus.mem_write_data;
    end
  end
  task automatic drive(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.req_write = w;
    bus.req_size = sz;
    bus.req_unsigned = u;
    bus.req_addr = a;
    bus.req_wdata = d;
    bus.req_valid = 1'b1;
    waited = 0;
    while (bus.req_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("accept", 32'(bus.req_ready), 32'd1);
    last_acc = cyc;
  endtask
  task automatic issue(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] erd, input logic eerr, input int lat, input int wlat, input logic [31:0] wdat,
                       input bit hold);
    drive(w, sz, u, a, d);
    rq.push_back(rsp_t'{erd, eerr, last_acc + lat});
    if (wlat > 0) wq.push_back(wr_t'{a & ~32'd3, wdat, last_acc + wlat});
    @(posedge clk);
    #1;
    if (!hold) bus.req_valid = 1'b0;
  endtask
  task automatic abort(input logic w, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d, input int skip);
    drive(w, sz, 1'b0, a, d);
    @(posedge clk);
    repeat (skip) @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_abort", 32'(bus.req_ready), 32'd1);
  endtask
  task automatic drain();
    for (int i = 0; i < 30 && (rq.size() != 0 || wq.size() != 0); i++) @(negedge clk);
    chk("rsp_pending", rq.size(), 32'd0);
    chk("write_pending", wq.size(), 32'd0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[4] = 32'h8844_22F1;
    mem[8] = 32'h1122_3344;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_write_enable), 32'd0);
    chk("rst_mem_addr", bus.mem_address, 32'd0);
    chk("rst_mem_wdata", bus.mem_write_data, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(bus.req_ready), 32'd1);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_rsp_error", 32'(bus.rsp_error), 32'd0);
    issue(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'hFFFF_FF88, 1'b0, 2, 0, 32'h0, 1'b0);
    issue(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'h0000_0088, 1'b0, 2, 0, 32'h0, 1'b0);
    issue(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'hFFFF_8844, 1'b0, 2, 0, 32'h0, 1'b0);
    issue(1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 32'h0000_00F1, 1'b0, 2, 0, 32'h0, 1'b0);
    issue(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 32'h0000_22F1, 1'b0, 2, 0, 32'h0, 1'b0);
    issue(1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFF_FFAB, 32'h0, 1'b0, 3, 2, 32'h8844_ABF1, 1'b0);
    issue(1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFF_1234, 32'h0, 1'b0, 3, 2, 32'h1234_ABF1, 1'b0);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h1234_ABF1, 1'b0, 2, 0, 32'h0, 1'b0);
    drain();
    chk("mem_10_after_stores", mem[4], 32'h1234_ABF1);
    issue(1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0, 1'b0);
    issue(1'b1, 2'b01, 1'b0, 32'h13, 32'h5555, 32'h0, 1'b1, 1, 0, 32'h0, 1'b0);
    issue(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0, 1'b0);
    issue(1'b1, 2'b11, 1'b0, 32'h10, 32'h7777, 32'h0, 1'b1, 1, 0, 32'h0, 1'b0);
    drain();
    chk("mem_10_after_errors", mem[4], 32'h1234_ABF1);
    abort(1'b1, 2'b00, 32'h20, 32'hCD, 0);
    abort(1'b1, 2'b10, 32'h20, 32'h99, 0);
    abort(1'b0, 2'b10, 32'h20, 32'h0, 1);
    repeat (4) @(negedge clk);
    chk("mem_20_after_aborts", mem[8], 32'h1122_3344);
    drain();
    issue(1'b1, 2'b10, 1'b0, 32'h24, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, 1, 32'hDEAD_BEEF, 1'b1);
    prev = last_acc;
    issue(1'b0, 2'b10, 1'b0, 32'h24, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, 0, 32'h0, 1'b0);
    chk("b2b_accept_cycle", last_acc, prev + 3);
    chk("b2b_ready_low_cycles", waited, 32'd2);
    @(negedge clk);
    chk("ready_low_in_load", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    chk("ready_low_in_resp", 32'(bus.req_ready), 32'd0);
    drain();
    chk("mem_24_after_store", mem[9], 32'hDEAD_BEEF);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store initiator that drives the single-port word memory (combinational read, synchronous word-aligned write) on behalf of the core's memory stage.
- Accepts byte/halfword/word load and store requests over a valid/ready handshake.
- Performs lane extraction and sign/zero extension for loads.
- Implements sub-word stores as read-merge-write, because the memory accepts only full aligned words.
- Returns one response pulse per request, flagging misaligned or illegal accesses without touching memory.

Parameters:
ADDR_W, 32, address width of request and memory ports (bits [1:0] select byte lane)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request
req_write  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  input  1  loads: zero-extend when 1, sign-extend when 0
req_addr  input  ADDR_W  byte address
req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
rsp_valid  output  1  one-cycle response pulse
rsp_rdata  output  32  extended load data; 0 for stores and errors
rsp_error  output  1  misaligned/illegal access, valid with rsp_valid
mem_address  output  ADDR_W  word address to memory, bits [1:0] always 00
mem_write_data  output  32  full word to write
mem_write_enable  output  1  write strobe
mem_read_data  input  32  combinational read data for mem_address

Behaviour:
- Reset values: state IDLE; rsp_valid=0, rsp_rdata=0, rsp_error=0, mem_address=0, mem_write_data=0, mem_write_enable=0; latched request cleared.
- req_ready=1 only in IDLE and only while reset=0. Acceptance = req_valid & req_ready. All request fields are latched at acceptance.
- Misalignment rule:
  - half with addr[0]=1 is misaligned.
  - word with addr[1:0]!=00 is misaligned.
  - size 11 is illegal.
- States and transitions:
  - IDLE: on acceptance:
    - error access -> RESP with error flag.
    - load -> LOAD.
    - word store -> STORE.
    - byte/half store -> MERGE.
  - LOAD: mem_address = {addr[ADDR_W-1:2],2'b00}; capture mem_read_data; extract the lane (byte lane = addr[1:0], half lane = addr[1]); extend per req_unsigned into the result register -> RESP.
  - MERGE: same mem_address; capture mem_read_data; replace the addressed byte/half lane with req_wdata[7:0]/[15:0]; other lanes unchanged -> STORE.
  - STORE: mem_address held; mem_write_data = merged word (word store: req_wdata); mem_write_enable = 1 for exactly this cycle -> RESP.
  - RESP: rsp_valid=1 for one cycle; rsp_error per latched flag; rsp_rdata = load result, else 0 -> IDLE.
- Latency from the acceptance cycle T:
  - load: rsp_valid at T+2.
  - word store: write at T+1, rsp at T+2.
  - sub-word store: write at T+2, rsp at T+3.
  - error: rsp at T+1, no memory write.
- rsp_rdata and rsp_error hold their value until the next RESP. Nothing is guaranteed outside rsp_valid.
- Outside LOAD/MERGE/STORE: mem_address = 0 and mem_write_enable = 0.
- mem_write_enable is gated by !reset, so no write is issued in a cycle where reset=1, including while in STORE.
- Reset mid-operation: the access is aborted; no write, no rsp_valid. req_ready=1 in the first cycle after reset deasserts.
- No request overlap: at most one request outstanding. A back-to-back request is accepted in the IDLE cycle following RESP.
- No re-ordering, no buffering beyond one request.

Test Plan:
1. Memory word 0x10 = 0x884422F1. Load byte signed at 0x13 -> rsp at T+2, rdata 0xFFFFFF88, error=0. Repeat unsigned -> 0x00000088.
2. Same word. Load half signed at 0x12 -> 0xFFFF8844. Load byte unsigned at 0x10 -> 0x000000F1.
3. Same word. Store byte 0xAB at 0x11 -> one write pulse at T+2, address 0x10, data 0x8844ABF1. rsp at T+3, rdata 0, error 0. Then store half 0x1234 at 0x12 -> word 0x1234ABF1.
4. Load word at 0x12; store half at 0x13; size 11 at 0x10 -> each gives rsp at T+1 with error=1 and rdata 0. mem_write_enable never asserted; memory unchanged.
5. Sub-word store 0xCD at 0x20 with reset asserted in the MERGE cycle -> no write pulse, no rsp_valid. Word 0x20 unchanged. req_ready=1 one cycle after reset falls.
6. req_valid held high: word store 0xDEADBEEF at 0x24, then load word 0x24 -> second acceptance in the cycle after the first RESP. Load rsp rdata 0xDEADBEEF. req_ready low throughout both operations.
